// File: rtl/bpu_pkg.sv
// Shared types and width/encoding helpers for the branch predictor.
// Entry fields use fixed maximum widths; the top only ever writes zero-extended values.
package bpu_pkg;
  localparam int TAG_W_MAX = 32;
  localparam int CTR_W_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [31:0]          target;
    logic [CTR_W_MAX-1:0] ctr;
  } btb_entry_t;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int pc_w, input int entries);
    return pc_w - $clog2(entries) - 2;
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_weak_t(input int cnt_w);
    return CTR_W_MAX'(1) << (cnt_w - 1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_weak_nt(input int cnt_w);
    return ctr_weak_t(cnt_w) - CTR_W_MAX'(1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_max(input int cnt_w);
    return (CTR_W_MAX'(1) << cnt_w) - CTR_W_MAX'(1);
  endfunction
endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Combinational next-state for a W-bit saturating counter; force_max wins over inc/dec.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         dec,
  input  logic         force_max,
  output logic [W-1:0] nxt
);
  always_comb begin
    nxt = cur;
    if (force_max)                nxt = '1;
    else if (inc && cur != '1)    nxt = cur + W'(1);
    else if (dec && cur != '0)    nxt = cur - W'(1);
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with saturating direction counters, EX-stage training,
// misprediction/redirect generation and saturating performance counters.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] f_pc,
  output logic            f_hit,
  output logic            f_taken,
  output logic [31:0]     f_target,
  input  logic            e_valid,
  input  logic [PC_W-1:0] e_pc,
  input  logic            e_branch,
  input  logic            e_jump,
  input  logic            e_jalr,
  input  logic            e_taken,
  input  logic [31:0]     e_target,
  input  logic            e_pred_taken,
  input  logic [31:0]     e_pred_target,
  output logic            e_flush,
  output logic [31:0]     e_redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(PC_W, ENTRIES);

  btb_entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  btb_entry_t       f_ent, e_ent;
  logic             e_hit;
  logic [CNT_W-1:0] ctr_nxt;
  logic [31:0]      br_nxt, mp_nxt;
  logic             unused_in;

  // Kind is implied by jump/jalr; byte-offset bits never take part in index/tag.
  assign unused_in = ^{f_pc[1:0], e_pc[1:0], e_branch};

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[PC_W-1:IDX_W+2];
  assign e_idx = e_pc[IDX_W+1:2];
  assign e_tag = e_pc[PC_W-1:IDX_W+2];
  assign f_ent = tbl[f_idx];
  assign e_ent = tbl[e_idx];

  assign f_hit    = f_ent.valid && (f_ent.tag == TAG_W_MAX'(f_tag));
  assign f_taken  = f_hit && f_ent.ctr[CNT_W-1];
  assign f_target = f_hit ? f_ent.target : 32'd0;
  assign e_hit    = e_ent.valid && (e_ent.tag == TAG_W_MAX'(e_tag));

  assign e_flush = e_valid && ((e_taken != e_pred_taken) ||
                               (e_taken && (e_target != e_pred_target)));
  assign e_redirect_pc = !e_flush ? 32'd0 :
                         e_taken  ? e_target : (32'(e_pc) + 32'd4);

  sat_counter #(.W(CNT_W)) u_dir_ctr (
    .cur(e_ent.ctr[CNT_W-1:0]), .inc(e_taken), .dec(!e_taken),
    .force_max(e_jump), .nxt(ctr_nxt)
  );
  sat_counter #(.W(32)) u_stat_br (
    .cur(stat_branches), .inc(e_valid), .dec(1'b0), .force_max(1'b0), .nxt(br_nxt)
  );
  sat_counter #(.W(32)) u_stat_mp (
    .cur(stat_mispredicts), .inc(e_flush), .dec(1'b0), .force_max(1'b0), .nxt(mp_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid  <= 1'b0;
        tbl[i].tag    <= '0;
        tbl[i].target <= '0;
        tbl[i].ctr    <= ctr_weak_nt(CNT_W);
      end
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_branches    <= br_nxt;
      stat_mispredicts <= mp_nxt;
      if (e_valid) begin
        if (e_jalr) begin
          // Indirect targets are not predictable here; drop any stale entry.
          if (e_hit) tbl[e_idx].valid <= 1'b0;
        end else if (e_hit) begin
          tbl[e_idx].ctr <= CTR_W_MAX'(ctr_nxt);
          if (e_taken) tbl[e_idx].target <= e_target;
        end else if (e_taken) begin
          tbl[e_idx].valid  <= 1'b1;
          tbl[e_idx].tag    <= TAG_W_MAX'(e_tag);
          tbl[e_idx].target <= e_target;
          tbl[e_idx].ctr    <= e_jump ? ctr_max(CNT_W) : ctr_weak_t(CNT_W);
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: rule-level model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  f_pc = '0, e_pc = '0;
  logic        f_hit, f_taken, e_flush;
  logic [31:0] f_target, e_redirect_pc, stat_branches, stat_mispredicts;
  logic        e_valid = 0, e_branch = 0, e_jump = 0, e_jalr = 0, e_taken = 0, e_pred_taken = 0;
  logic [31:0] e_target = '0, e_pred_target = '0;

  int checks = 0, failures = 0;

  branch_predict_unit #(.PC_W(9), .ENTRIES(16), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_hit(f_hit), .f_taken(f_taken),
    .f_target(f_target), .e_valid(e_valid), .e_pc(e_pc), .e_branch(e_branch),
    .e_jump(e_jump), .e_jalr(e_jalr), .e_taken(e_taken), .e_target(e_target),
    .e_pred_taken(e_pred_taken), .e_pred_target(e_pred_target), .e_flush(e_flush),
    .e_redirect_pc(e_redirect_pc), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  // ---------------- model: table as plain int arrays ----------------
  bit      m_valid [16];
  int      m_tag   [16];
  longint  m_tgt   [16];
  int      m_ctr   [16];
  longint  m_br, m_mp;

  function automatic int idx_of(input logic [8:0] pc); return (int'(pc) / 4) % 16; endfunction
  function automatic int tag_of(input logic [8:0] pc); return int'(pc) / 64; endfunction

  function automatic bit m_flush();
    return e_valid && ((e_taken != e_pred_taken) || (e_taken && e_target != e_pred_target));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_br = 0; m_mp = 0;
    end else begin
      if (m_flush() && m_mp < 64'hFFFF_FFFF) m_mp = m_mp + 1;
      if (e_valid) begin
        int i; bit hit;
        i = idx_of(e_pc);
        hit = m_valid[i] && m_tag[i] == tag_of(e_pc);
        if (m_br < 64'hFFFF_FFFF) m_br = m_br + 1;
        if (e_jalr) begin
          if (hit) m_valid[i] = 0;
        end else if (hit) begin
          if (e_jump)       m_ctr[i] = 3;
          else if (e_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          else              m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
          if (e_taken) m_tgt[i] = longint'(e_target);
        end else if (e_taken) begin
          m_valid[i] = 1; m_tag[i] = tag_of(e_pc); m_tgt[i] = longint'(e_target);
          m_ctr[i] = e_jump ? 3 : 2;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    int  i;
    bit  hit;
    i = idx_of(f_pc);
    hit = m_valid[i] && m_tag[i] == tag_of(f_pc);
    chk("m_f_hit",    f_hit, hit);
    chk("m_f_taken",  f_taken, hit && m_ctr[i] >= 2);
    chk("m_f_target", f_target, hit ? m_tgt[i] : 0);
    chk("m_e_flush",  e_flush, m_flush());
    chk("m_redirect", e_redirect_pc,
        !m_flush() ? 0 : e_taken ? longint'(e_target) : ((longint'(e_pc) + 4) & 64'hFFFF_FFFF));
    chk("m_stat_br",  stat_branches, m_br);
    chk("m_stat_mp",  stat_mispredicts, m_mp);
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic resolve(input logic [8:0] pc, input bit br, input bit jp, input bit jr,
                         input bit tk, input logic [31:0] tgt, input bit ptk,
                         input logic [31:0] ptgt);
    e_valid = 1; e_pc = pc; e_branch = br; e_jump = jp; e_jalr = jr;
    e_taken = tk; e_target = tgt; e_pred_taken = ptk; e_pred_target = ptgt;
  endtask

  task automatic idle();
    e_valid = 0; e_branch = 0; e_jump = 0; e_jalr = 0; e_taken = 0;
    e_target = '0; e_pred_taken = 0; e_pred_target = '0;
  endtask

  initial begin
    #1 reset = 1'b0;
    step(); step();
    reset = 1'b1; f_pc = 9'h010;
    #2;
    chk("rst_f_hit", f_hit, 0); chk("rst_f_taken", f_taken, 0);
    chk("rst_f_target", f_target, 0);
    chk("rst_stat_br", stat_branches, 0); chk("rst_stat_mp", stat_mispredicts, 0);

    // Cold taken branch allocates weakly-taken.
    step();
    resolve(9'h010, 1, 0, 0, 1, 32'h40, 0, 32'h0);
    #2 chk("cold_flush", e_flush, 1); chk("cold_redirect", e_redirect_pc, 32'h40);
    step(); idle();
    #2 chk("cold_hit", f_hit, 1); chk("cold_taken", f_taken, 1);
    chk("cold_target", f_target, 32'h40);
    chk("cold_stat_br", stat_branches, 1); chk("cold_stat_mp", stat_mispredicts, 1);

    // Training down: 10 -> 01 -> 00 -> 00.
    resolve(9'h010, 1, 0, 0, 0, 32'h0, 1, 32'h40);
    #2 chk("nt1_flush", e_flush, 1); chk("nt1_redirect", e_redirect_pc, 32'h14);
    step();
    resolve(9'h010, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    #2 chk("nt2_flush", e_flush, 0); chk("nt2_redirect", e_redirect_pc, 0);
    step();
    step(); idle();
    #2 chk("nt3_taken", f_taken, 0); chk("nt3_hit", f_hit, 1);
    // One taken from 00 must only reach 01; a wrapped counter would predict taken.
    resolve(9'h010, 1, 0, 0, 1, 32'h40, 0, 32'h0);
    step(); idle();
    #2 chk("sat_lo_taken", f_taken, 0);
    resolve(9'h010, 1, 0, 0, 1, 32'h40, 0, 32'h0);
    step(); idle();
    #2 chk("up_taken", f_taken, 1);

    // e_valid low with disagreeing inputs: no flush.
    e_taken = 1; e_target = 32'h55; e_pred_taken = 0;
    #2 chk("idle_flush", e_flush, 0); chk("idle_redirect", e_redirect_pc, 0);
    step(); idle();

    // Alias at index 4, tag 1, evicts 0x010.
    resolve(9'h050, 1, 0, 0, 1, 32'h80, 0, 32'h0);
    step(); idle();
    #2 chk("alias_old_miss", f_hit, 0);
    f_pc = 9'h050;
    #1 chk("alias_new_hit", f_hit, 1); chk("alias_new_tgt", f_target, 32'h80);
    step();
    resolve(9'h050, 0, 0, 1, 1, 32'h200, 0, 32'h0);
    #2 chk("jalr_flush", e_flush, 1); chk("jalr_redirect", e_redirect_pc, 32'h200);
    step(); idle();
    #2 chk("jalr_inval", f_hit, 0);

    // Jump allocates strongly taken, then stale target retrains.
    resolve(9'h020, 0, 1, 0, 1, 32'h100, 0, 32'h0);
    f_pc = 9'h020;
    step(); idle();
    #2 chk("jump_hit", f_hit, 1); chk("jump_taken", f_taken, 1);
    chk("jump_tgt", f_target, 32'h100);
    resolve(9'h020, 0, 1, 0, 1, 32'h104, 1, 32'h100);
    #2 chk("stale_flush", e_flush, 1); chk("stale_redirect", e_redirect_pc, 32'h104);
    step(); idle();
    #2 chk("stale_tgt", f_target, 32'h104);

    // Same-cycle lookup sees pre-update contents.
    resolve(9'h020, 0, 0, 1, 1, 32'h300, 1, 32'h300);
    #2 chk("coll_old_hit", f_hit, 1); chk("coll_old_tgt", f_target, 32'h104);
    chk("coll_no_flush", e_flush, 0);
    step(); idle();
    #2 chk("coll_after", f_hit, 0);

    // Not-taken fallthrough at top of PC range.
    resolve(9'h1FC, 1, 0, 0, 0, 32'h0, 1, 32'h8);
    #2 chk("top_redirect", e_redirect_pc, 32'h200);
    step(); idle();

    // Mid-stream reset clears table and stats before the next edge.
    resolve(9'h020, 0, 1, 0, 1, 32'h100, 0, 32'h0);
    step();
    resolve(9'h030, 1, 0, 0, 1, 32'h44, 0, 32'h0);
    #1 chk("pre_rst_hit", f_hit, 1);
    reset = 1'b0;
    #1 chk("mid_rst_hit", f_hit, 0); chk("mid_rst_br", stat_branches, 0);
    chk("mid_rst_mp", stat_mispredicts, 0);
    step(); idle();
    reset = 1'b1;
    step();
    f_pc = 9'h030;
    #1 chk("lost_update", f_hit, 0);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
